// File: rtl/alu_result_skid.sv
// Two-entry skid buffer between the 20-bit ALU word units and writeback.
// Also holds the architectural Z flag, which is updated when a flag-writing result retires.
module alu_result_skid #(
  parameter int WIDTH = 20,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_c,
  input  logic             in_zero,
  input  logic             in_wr_flags,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_c,
  output logic             out_zero,
  output logic             out_wr_flags,
  output logic             flag_z,
  output logic [1:0]       count
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_t;

  localparam logic [1:0] FULL = 2'(DEPTH);

  state_t           state;
  logic [WIDTH-1:0] tail_c;
  logic             tail_zero;
  logic             tail_wr_flags;
  logic             in_xfer;
  logic             out_xfer;

  // Occupancy is the state itself, so in_ready never depends on out_ready.
  assign count     = state;
  assign in_ready  = (count != FULL);
  assign out_valid = (state != EMPTY);
  assign in_xfer   = in_valid & in_ready;
  assign out_xfer  = out_valid & out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= EMPTY;
      out_c         <= '0;
      out_zero      <= 1'b0;
      out_wr_flags  <= 1'b0;
      tail_c        <= '0;
      tail_zero     <= 1'b0;
      tail_wr_flags <= 1'b0;
      flag_z        <= 1'b0;
    end else begin
      // A retiring head updates Z even when the same edge flushes the buffer.
      if (out_xfer && out_wr_flags) begin
        flag_z <= out_zero;
      end

      if (flush) begin
        state         <= EMPTY;
        out_c         <= '0;
        out_zero      <= 1'b0;
        out_wr_flags  <= 1'b0;
        tail_c        <= '0;
        tail_zero     <= 1'b0;
        tail_wr_flags <= 1'b0;
      end else begin
        case (state)
          EMPTY: begin
            if (in_xfer) begin
              out_c        <= in_c;
              out_zero     <= in_zero;
              out_wr_flags <= in_wr_flags;
              state        <= ONE;
            end
          end
          ONE: begin
            if (in_xfer && out_xfer) begin
              out_c        <= in_c;
              out_zero     <= in_zero;
              out_wr_flags <= in_wr_flags;
            end else if (in_xfer) begin
              tail_c        <= in_c;
              tail_zero     <= in_zero;
              tail_wr_flags <= in_wr_flags;
              state         <= TWO;
            end else if (out_xfer) begin
              state <= EMPTY;
            end
          end
          TWO: begin
            if (out_xfer) begin
              out_c        <= tail_c;
              out_zero     <= tail_zero;
              out_wr_flags <= tail_wr_flags;
              state        <= ONE;
            end
          end
          default: state <= EMPTY;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_alu_result_skid.sv
// Scoreboard bench for alu_result_skid: the driver queues accepted results,
// a negedge monitor retires them and checks order, occupancy and the Z flag.
module tb_alu_result_skid;

  typedef struct packed {
    logic [19:0] c;
    logic        z;
    logic        w;
  } ent_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [19:0] in_c;
  logic        in_zero;
  logic        in_wr_flags;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [19:0] out_c;
  logic        out_zero;
  logic        out_wr_flags;
  logic        flag_z;
  logic [1:0]  count;

  ent_t sb_q[$];
  logic exp_flag     = 1'b0;
  logic data_cleared = 1'b1;
  logic mon_en       = 1'b0;
  int   vectors      = 0;
  int   miscompares  = 0;

  alu_result_skid #(.WIDTH(20), .DEPTH(2)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_c         (in_c),
    .in_zero      (in_zero),
    .in_wr_flags  (in_wr_flags),
    .flush        (flush),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_c        (out_c),
    .out_zero     (out_zero),
    .out_wr_flags (out_wr_flags),
    .flag_z       (flag_z),
    .count        (count)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Monitor: occupancy and flag come from the queue; a retiring head is popped and compared.
  task automatic checkOutput();
    ent_t e;
    int   n;
    n = sb_q.size();
    check("count", 32'(count), 32'(n));
    check("in_ready", 32'(in_ready), 32'(n != 2));
    check("out_valid", 32'(out_valid), 32'(n != 0));
    check("flag_z", 32'(flag_z), 32'(exp_flag));
    if (data_cleared) begin
      check("cleared_out", {11'd0, out_c, out_zero}, 32'd0);
    end
    if (out_ready && n > 0) begin
      e = sb_q.pop_front();
      check("out_c", 32'(out_c), 32'(e.c));
      check("out_zero", 32'(out_zero), 32'(e.z));
      check("out_wr_flags", 32'(out_wr_flags), 32'(e.w));
      if (e.w) exp_flag = e.z;
    end
  endtask

  always @(negedge clk) begin
    if (mon_en) checkOutput();
  end

  // Drives one cycle; called just after a rising edge, returns just after the next.
  task automatic applyStimulus(input logic v, input logic [19:0] c, input logic z,
                               input logic w, input logic ordy, input logic fl);
    logic was_full;
    in_valid    = v;
    in_c        = c;
    in_zero     = z;
    in_wr_flags = w;
    out_ready   = ordy;
    flush       = fl;
    was_full    = (sb_q.size() == 2);
    @(posedge clk);
    #1;
    if (fl) begin
      sb_q.delete();
      data_cleared = 1'b1;
    end else if (v && !was_full) begin
      sb_q.push_back('{c: c, z: z, w: w});
      data_cleared = 1'b0;
    end
  endtask

  task automatic doReset();
    mon_en      = 1'b0;
    in_valid    = 1'b1;
    in_c        = 20'hFFFFF;
    in_zero     = 1'b1;
    in_wr_flags = 1'b1;
    out_ready   = 1'b1;
    flush       = 1'b0;
    #1;
    rst_n = 1'b0;
    sb_q.delete();
    exp_flag     = 1'b0;
    data_cleared = 1'b1;
    #1;
    check("rst_count", 32'(count), 32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_data", {11'd0, out_c, out_zero}, 32'd0);
    check("rst_out_wr", 32'(out_wr_flags), 32'd0);
    check("rst_flag_z", 32'(flag_z), 32'd0);
    in_valid = 1'b0;
    #1;
    rst_n = 1'b1;
    #1;
    check("rst_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;
    mon_en = 1'b1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 20'($urandom), 1'b1, 1'b1, 1'b1, 1'b0);
  endtask

  initial begin
    rst_n       = 1'b0;
    in_valid    = 1'b0;
    in_c        = '0;
    in_zero     = 1'b0;
    in_wr_flags = 1'b0;
    out_ready   = 1'b0;
    flush       = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    doReset();

    $display("[TB] pass-through");
    applyStimulus(1'b1, 20'h000FF, 1'b0, 1'b1, 1'b1, 1'b0);
    applyStimulus(1'b1, 20'h00000, 1'b1, 1'b1, 1'b1, 1'b0);
    idle(3);

    $display("[TB] backpressure");
    applyStimulus(1'b1, 20'h12345, 1'b0, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 20'hABCDE, 1'b0, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 20'h0F0F0, 1'b0, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 20'h0F0F0, 1'b0, 1'b0, 1'b1, 1'b0);
    applyStimulus(1'b1, 20'h0F0F0, 1'b0, 1'b0, 1'b1, 1'b0);
    idle(3);

    $display("[TB] simultaneous transfer in ONE");
    applyStimulus(1'b1, 20'h00001, 1'b0, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 20'h00002, 1'b0, 1'b0, 1'b1, 1'b0);
    idle(2);

    $display("[TB] flag gating");
    doReset();
    applyStimulus(1'b1, 20'h00000, 1'b1, 1'b0, 1'b1, 1'b0);
    idle(2);
    applyStimulus(1'b1, 20'h00000, 1'b1, 1'b1, 1'b1, 1'b0);
    idle(2);

    $display("[TB] flush");
    applyStimulus(1'b1, 20'hAAAAA, 1'b0, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b1, 20'h55555, 1'b1, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b1, 20'hFFFFF, 1'b1, 1'b1, 1'b1, 1'b1);
    idle(3);

    $display("[TB] random traffic");
    for (int i = 0; i < 800; i++) begin
      if (i == 400) doReset();
      applyStimulus(1'($urandom_range(0, 99) < 70), 20'($urandom), 1'($urandom),
                    1'($urandom), 1'($urandom_range(0, 99) < 60),
                    1'($urandom_range(0, 99) < 3));
    end
    idle(4);

    mon_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
